// File: rtl/uart_tx_sched.sv
// uart_tx_sched: four-requester round-robin scheduler in front of a single
// 8N1 UART transmitter (LSB first, idle-high line).
//
// Parameters
//   CLK_DIV  system clocks per UART bit (2..65535)
//
// Ports
//   clk    system clock, rising edge
//   rst    synchronous active-high reset
//   req    per-requester transmit request (level)
//   din    requester payloads, requester i on din[8i+7:8i]
//   grant  one-hot single-cycle pulse: requester byte accepted
//   owner  requester owning the current or most recent frame
//   busy   high while a frame is on the line
//   done   single-cycle pulse on the last clock of the stop bit
//   tx     serial output
module uart_tx_sched #(
   parameter int unsigned CLK_DIV = 10416
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  req,
   input  logic [31:0] din,
   output logic [3:0]  grant,
   output logic [1:0]  owner,
   output logic        busy,
   output logic        done,
   output logic        tx
);

   localparam int unsigned TW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam logic [TW-1:0] T_LAST = TW'(CLK_DIV - 1);
   localparam logic [TW-1:0] T_DONE = TW'(CLK_DIV - 2);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t        state;
   logic [TW-1:0] timer;
   logic [2:0]    bit_idx;
   logic [7:0]    shreg;
   logic [1:0]    ptr;

   logic [1:0]    sel;
   logic          found;
   logic          bit_end;

   // Round-robin pick: first requester at or after ptr, wrapping.
   // Iterating from the farthest offset down lets the nearest one win.
   always_comb begin
      sel   = ptr;
      found = 1'b0;
      for (int i = 3; i >= 0; i--) begin
         if (req[ptr + 2'(i)]) begin
            sel   = ptr + 2'(i);
            found = 1'b1;
         end
      end
   end

   assign bit_end = (timer == T_LAST);

   // Frame sequencer; every output is a register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         timer   <= '0;
         bit_idx <= '0;
         shreg   <= '0;
         ptr     <= '0;
         owner   <= '0;
         grant   <= '0;
         done    <= 1'b0;
         busy    <= 1'b0;
         tx      <= 1'b1;
      end else begin
         grant <= '0;
         done  <= 1'b0;

         case (state)
            IDLE: begin
               timer   <= '0;
               bit_idx <= '0;
               if (found) begin
                  shreg <= din[8*sel +: 8];
                  owner <= sel;
                  ptr   <= sel + 2'd1;
                  grant <= 4'b0001 << sel;
                  tx    <= 1'b0;
                  busy  <= 1'b1;
                  state <= START;
               end else begin
                  tx   <= 1'b1;
                  busy <= 1'b0;
               end
            end

            START: begin
               if (bit_end) begin
                  timer   <= '0;
                  bit_idx <= '0;
                  tx      <= shreg[0];
                  state   <= DATA;
               end else begin
                  timer <= timer + TW'(1);
               end
            end

            // Shift register always presents the bit on the line at [0];
            // the next bit is therefore shreg[1] at each boundary.
            DATA: begin
               if (bit_end) begin
                  timer <= '0;
                  if (bit_idx == 3'd7) begin
                     tx    <= 1'b1;
                     state <= STOP;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                     shreg   <= {1'b0, shreg[7:1]};
                     tx      <= shreg[1];
                  end
               end else begin
                  timer <= timer + TW'(1);
               end
            end

            // done is registered one clock early so it is high during the
            // final stop-bit clock, before IDLE is re-entered.
            STOP: begin
               tx <= 1'b1;
               if (bit_end) begin
                  timer <= '0;
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  timer <= timer + TW'(1);
                  done  <= (timer == T_DONE);
               end
            end

            default: begin
               state <= IDLE;
               tx    <= 1'b1;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
